// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receive stage.
package sipo_pkg;

    // Word-assembly state: IDLE between words, SHIFT while a partial word is held.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width able to represent 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-word holding register with valid/ready output handshake and sticky overflow.
module sipo_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overflow;
    logic             w_xfer;

    // A transfer frees the slot on the same edge, so a completing word can replace it.
    assign w_xfer = r_valid && i_ready;

    // Load a completed word, retire a consumed one, or record a dropped word.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (i_load) begin
                if (!r_valid || w_xfer) begin
                    r_dout  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (i_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles WIDTH strobed bits into a word and
// hands it to a one-word holding register with a valid/ready output.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_done;

    // Shift direction decides which end of the word the first bit reaches.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sreg_next = {r_sreg[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign w_sreg_next = {sin, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    // Count including the bit sampled on this edge; completion when it reaches WIDTH.
    assign w_cnt_next = (r_state == IDLE) ? CW'(1) : (r_cnt + CW'(1));
    assign w_done     = sin_valid && !clear && (w_cnt_next == CW'(WIDTH));

    // Word-assembly FSM: clear aborts, a strobed bit shifts in, the last bit completes.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (sin_valid) begin
            r_sreg <= w_sreg_next;
            if (w_done) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= SHIFT;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    assign busy = (r_state == SHIFT);

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock      (clock),
        .rst        (rst),
        .i_load     (w_done),
        .i_word     (w_sreg_next),
        .i_ready    (dout_ready),
        .i_clear    (clear),
        .o_dout     (dout),
        .o_valid    (dout_valid),
        .o_overflow (overflow)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance
// share one set of stimulus inputs.
module tb_sipo_deserializer;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       clear;
    logic       dout_ready;
    logic [3:0] m_dout, l_dout;
    logic       m_valid, l_valid;
    logic       m_busy, l_busy;
    logic       m_ovf, l_ovf;

    int checks = 0;
    int errors = 0;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clock      (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .clear      (clear),
        .dout       (m_dout),
        .dout_valid (m_valid),
        .dout_ready (dout_ready),
        .busy       (m_busy),
        .overflow   (m_ovf)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clock      (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .clear      (clear),
        .dout       (l_dout),
        .dout_valid (l_valid),
        .dout_ready (dout_ready),
        .busy       (l_busy),
        .overflow   (l_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sin;
        logic       sv;
        logic       rdy;
        logic       clr;
        logic [3:0] edout;
        logic       evld;
        logic       ebusy;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic v, input logic r, input logic c,
                       input logic [3:0] d, input logic ev, input logic eb, input logic eo);
        vec_t t;
        t.sin = s; t.sv = v; t.rdy = r; t.clr = c;
        t.edout = d; t.evld = ev; t.ebusy = eb; t.eovf = eo;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic r, input logic c);
        sin = s; sin_valid = v; dout_ready = r; clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_msb(input string tag, input int idx, input logic [3:0] d,
                             input logic v, input logic b, input logic o);
        check({tag, "_dout"}, idx, 32'(m_dout), 32'(d));
        check({tag, "_valid"}, idx, 32'(m_valid), 32'(v));
        check({tag, "_busy"}, idx, 32'(m_busy), 32'(b));
        check({tag, "_ovf"}, idx, 32'(m_ovf), 32'(o));
    endtask

    task automatic check_lsb(input string tag, input int idx, input logic [3:0] d,
                             input logic v, input logic b, input logic o);
        check({tag, "_ldout"}, idx, 32'(l_dout), 32'(d));
        check({tag, "_lvalid"}, idx, 32'(l_valid), 32'(v));
        check({tag, "_lbusy"}, idx, 32'(l_busy), 32'(b));
        check({tag, "_lovf"}, idx, 32'(l_ovf), 32'(o));
    endtask

    initial begin
        sin = 0; sin_valid = 0; clear = 0; dout_ready = 0; rst = 0;

        // Reset held, then idle after release.
        repeat (2) @(posedge clk);
        #1;
        check_msb("rst", 0, 4'h0, 0, 0, 0);
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check_msb("idle", i, 4'h0, 0, 0, 0);
            check_lsb("idle", i, 4'h0, 0, 0, 0);
        end

        // Basic receive 0101, then consume.
        add(0,1,0,0, 4'h0,0,1,0);
        add(1,1,0,0, 4'h0,0,1,0);
        add(0,1,0,0, 4'h0,0,1,0);
        add(1,1,0,0, 4'h5,1,0,0);
        add(0,0,1,0, 4'h5,0,0,0);
        // Back-to-back with ready held high: 1110 then 0011.
        add(1,1,1,0, 4'h5,0,1,0);
        add(1,1,1,0, 4'h5,0,1,0);
        add(1,1,1,0, 4'h5,0,1,0);
        add(0,1,1,0, 4'hE,1,0,0);
        add(0,1,1,0, 4'hE,0,1,0);
        add(0,1,1,0, 4'hE,0,1,0);
        add(1,1,1,0, 4'hE,0,1,0);
        add(1,1,1,0, 4'h3,1,0,0);
        add(0,0,1,0, 4'h3,0,0,0);
        // Overflow: 0101 held, 1111 dropped.
        add(0,1,0,0, 4'h3,0,1,0);
        add(1,1,0,0, 4'h3,0,1,0);
        add(0,1,0,0, 4'h3,0,1,0);
        add(1,1,0,0, 4'h5,1,0,0);
        add(1,1,0,0, 4'h5,1,1,0);
        add(1,1,0,0, 4'h5,1,1,0);
        add(1,1,0,0, 4'h5,1,1,0);
        add(1,1,0,0, 4'h5,1,0,1);
        add(0,0,0,1, 4'h5,1,0,0);
        // Abort after two bits, then 1001.
        add(0,0,1,0, 4'h5,0,0,0);
        add(1,1,0,0, 4'h5,0,1,0);
        add(0,1,0,0, 4'h5,0,1,0);
        add(0,0,0,1, 4'h5,0,0,0);
        add(1,1,0,0, 4'h5,0,1,0);
        add(0,1,0,0, 4'h5,0,1,0);
        add(0,1,0,0, 4'h5,0,1,0);
        add(1,1,0,0, 4'h9,1,0,0);
        // Clear on the completing bit discards the word.
        add(0,0,1,0, 4'h9,0,0,0);
        add(1,1,0,0, 4'h9,0,1,0);
        add(1,1,0,0, 4'h9,0,1,0);
        add(1,1,0,0, 4'h9,0,1,0);
        add(0,1,0,1, 4'h9,0,0,0);
        add(0,0,0,0, 4'h9,0,0,0);

        foreach (vecs[i]) begin
            step(vecs[i].sin, vecs[i].sv, vecs[i].rdy, vecs[i].clr);
            check_msb("vec", i, vecs[i].edout, vecs[i].evld, vecs[i].ebusy, vecs[i].eovf);
        end

        // Gapped LSB-first word: bits 0,1, three idle cycles, then 1,1.
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("gap_lbusy", i, 32'(l_busy), 32'd1);
            check("gap_lvalid", i, 32'(l_valid), 32'd0);
        end
        step(1, 1, 0, 0);
        check("gap_lbusy3", 0, 32'(l_busy), 32'd1);
        step(1, 1, 0, 0);
        check_lsb("gap", 0, 4'hE, 1, 0, 0);
        check_msb("gap", 0, 4'h7, 1, 0, 0);

        // Asynchronous reset mid-word with a word still held.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("pre_rst_busy", 0, 32'(m_busy), 32'd1);
        sin_valid = 0;
        #3 rst = 0;
        #1;
        check_msb("arst", 0, 4'h0, 0, 0, 0);
        check_lsb("arst", 0, 4'h0, 0, 0, 0);
        #2 rst = 1;
        step(0, 0, 1, 0);
        check_msb("post_rst", 0, 4'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
